// File: rtl/game_pkg.sv
// game_pkg: shared state codes, score geometry and default score tick divider
package game_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_ATTRACT = 2'd0;
  localparam state_t ST_RUNNING = 2'd1;
  localparam state_t ST_DYING = 2'd2;
  localparam state_t ST_GAME_OVER = 2'd3;
  localparam int BCD_DIGITS = 4;
  localparam int SCORE_W = 16;
  localparam int TICK_DIV_DEFAULT = 2517500;
endpackage

// File: rtl/game_sequencer_btn_debounce.sv
// btn_debounce: 2-flop sync + stable-level debounce of btn, start_evt pulses once per accepted rising edge
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic start_evt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);
  logic s0, s1, lvl;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
      start_evt <= 1'b0;
    end else begin
      s0 <= btn;
      s1 <= s0;
      cnt <= (s1 == lvl || cnt == CNT_TC) ? '0 : cnt + 1'b1;
      lvl <= (s1 != lvl && cnt == CNT_TC) ? s1 : lvl;
      start_evt <= s1 && !lvl && cnt == CNT_TC;
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: dino game flow FSM; in clk/reset/btn/collision, out score_halt/score_reset/score_tick/cur_score/hi_score/game_over/state
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DEB_CYCLES = 250000,
  parameter int DEATH_CYCLES = 12587500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn,
  input  logic               collision,
  output logic               score_halt,
  output logic               score_reset,
  output logic               score_tick,
  output logic [SCORE_W-1:0] cur_score,
  output logic [SCORE_W-1:0] hi_score,
  output logic               game_over,
  output logic [1:0]         state
);
  localparam int DVW = $clog2(TICK_DIV + 1);
  localparam int DTW = $clog2(DEATH_CYCLES + 1);
  localparam logic [DVW-1:0] DIV_TC = DVW'(TICK_DIV - 1);
  localparam logic [DTW-1:0] DEATH_TC = DTW'(DEATH_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {BCD_DIGITS{4'd9}};
  logic start_evt, start, run, tc, death_tc;
  state_t state_n;
  logic [DVW-1:0] div;
  logic [DTW-1:0] death;
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic c;
    bcd_inc = v;
    c = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (c) begin
        bcd_inc[4*i+:4] = (v[4*i+:4] == 4'd9) ? 4'd0 : v[4*i+:4] + 4'd1;
        c = v[4*i+:4] == 4'd9;
      end
    if (v == SCORE_MAX) bcd_inc = v;
  endfunction
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .start_evt(start_evt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_ATTRACT;
      score_halt <= 1'b1;
      score_reset <= 1'b0;
      score_tick <= 1'b0;
      game_over <= 1'b0;
      cur_score <= '0;
      hi_score <= '0;
      div <= '0;
      death <= '0;
    end else begin
      state <= state_n;
      score_halt <= state_n != ST_RUNNING;
      score_reset <= start;
      score_tick <= tc;
      game_over <= state_n == ST_GAME_OVER;
      cur_score <= start ? '0 : tc ? bcd_inc(cur_score) : cur_score;
      hi_score <= (death_tc && cur_score > hi_score) ? cur_score : hi_score;
      div <= (start || tc) ? '0 : run ? div + 1'b1 : div;
      death <= (state == ST_DYING && !death_tc) ? death + 1'b1 : '0;
    end
  always_comb begin
    state_n = state;
    case (state)
      ST_ATTRACT, ST_GAME_OVER: state_n = start_evt ? ST_RUNNING : state;
      ST_RUNNING: state_n = collision ? ST_DYING : state;
      default: state_n = death_tc ? ST_GAME_OVER : state;
    endcase
  end
  // collision wins over a same-cycle terminal count, so run excludes it
  always_comb begin
    start = (state == ST_ATTRACT || state == ST_GAME_OVER) && start_evt;
    run = state == ST_RUNNING && !collision;
    tc = run && div == DIV_TC;
    death_tc = state == ST_DYING && death == DEATH_TC;
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer
module tb_game_sequencer;
  logic clk = 1'b0, reset, btn, collision, btn_s, collision_s;
  logic score_halt, score_reset, score_tick, game_over;
  logic [15:0] cur_score, hi_score;
  logic [1:0] state;
  logic s_halt, s_reset, s_tick, s_over;
  logic [15:0] s_cur, s_hi;
  logic [1:0] s_state;
  int passed = 0, total = 0, nt = 0, nr = 0, base = 0;
  always #5 clk = ~clk;
  game_sequencer #(.TICK_DIV(10), .DEB_CYCLES(4), .DEATH_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .btn(btn), .collision(collision),
    .score_halt(score_halt), .score_reset(score_reset), .score_tick(score_tick),
    .cur_score(cur_score), .hi_score(hi_score), .game_over(game_over), .state(state)
  );
  game_sequencer #(.TICK_DIV(1), .DEB_CYCLES(4), .DEATH_CYCLES(8)) dut_s (
    .clk(clk), .reset(reset), .btn(btn_s), .collision(collision_s),
    .score_halt(s_halt), .score_reset(s_reset), .score_tick(s_tick),
    .cur_score(s_cur), .hi_score(s_hi), .game_over(s_over), .state(s_state)
  );
  always @(negedge clk) begin
    if (score_tick) nt++;
    if (score_reset) nr++;
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic press();
    btn = 1'b1;
    step(6);
    btn = 1'b0;
    step(1);
    chk("start_state", state, 1);
    chk("start_reset_pulse", score_reset, 1);
    chk("start_cur_clear", cur_score, 16'h0000);
    chk("start_halt", score_halt, 0);
    step(1);
    chk("reset_pulse_end", score_reset, 0);
  endtask
  initial begin
    reset = 1'b1;
    btn = 1'b0;
    collision = 1'b0;
    btn_s = 1'b0;
    collision_s = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_state", state, 0);
    chk("rst_halt", score_halt, 1);
    chk("rst_sreset", score_reset, 0);
    chk("rst_tick", score_tick, 0);
    chk("rst_cur", cur_score, 16'h0000);
    chk("rst_hi", hi_score, 16'h0000);
    chk("rst_over", game_over, 0);
    step(50);
    chk("idle_state", state, 0);
    chk("idle_halt", score_halt, 1);
    chk("idle_ticks", nt, 0);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(10);
    chk("glitch_state", state, 0);
    chk("glitch_resets", nr, 0);
    press();
    step(8);
    chk("pre_first_tick", score_tick, 0);
    step(1);
    chk("first_tick", score_tick, 1);
    chk("first_score", cur_score, 16'h0001);
    step(110);
    chk("score_12", cur_score, 16'h0012);
    chk("one_reset_pulse", nr, 1);
    step(9);
    chk("pre_coll_tick", score_tick, 0);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    btn = 1'b1;
    chk("coll_state", state, 2);
    chk("coll_no_tick", score_tick, 0);
    chk("coll_score", cur_score, 16'h0012);
    chk("coll_halt", score_halt, 1);
    step(7);
    chk("dying_state", state, 2);
    step(1);
    chk("over_state", state, 3);
    chk("over_flag", game_over, 1);
    chk("over_hi", hi_score, 16'h0012);
    step(10);
    chk("dying_press_ignored", state, 3);
    btn = 1'b0;
    step(10);
    collision = 1'b1;
    step(3);
    collision = 1'b0;
    chk("over_coll_ignored", state, 3);
    press();
    chk("game2_hi_kept", hi_score, 16'h0012);
    step(70);
    chk("game2_score", cur_score, 16'h0007);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    chk("game2_dying", state, 2);
    step(8);
    chk("game2_over", state, 3);
    chk("game2_hi", hi_score, 16'h0012);
    chk("game2_cur_held", cur_score, 16'h0007);
    base = nt;
    press();
    step(349);
    chk("score_35", cur_score, 16'h0035);
    chk("tick_35", score_tick, 1);
    step(5);
    chk("ticks_35", nt - base, 35);
    reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_hi", hi_score, 16'h0000);
    chk("midrst_cur", cur_score, 16'h0000);
    chk("midrst_halt", score_halt, 1);
    step(2);
    reset = 1'b0;
    step(2);
    btn_s = 1'b1;
    step(6);
    btn_s = 1'b0;
    step(1);
    chk("sat_start", s_state, 1);
    step(9);
    chk("sat_9", s_cur, 16'h0009);
    step(1);
    chk("sat_10", s_cur, 16'h0010);
    step(90);
    chk("sat_100", s_cur, 16'h0100);
    step(900);
    chk("sat_1000", s_cur, 16'h1000);
    step(8998);
    chk("sat_9998", s_cur, 16'h9998);
    step(1);
    chk("sat_9999", s_cur, 16'h9999);
    chk("sat_tick_a", s_tick, 1);
    step(1);
    chk("sat_hold", s_cur, 16'h9999);
    chk("sat_tick_b", s_tick, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the dino runner.
- Sequences the on-screen score datapath: drives its halt/reset, generates the score tick, keeps the BCD score and the high score.
- Sits between the player button, the collision detector and the score/sprite renderers.
- All outputs are registered in the single `clk` domain.

Parameters:
- TICK_DIV, 2517500: clk cycles per score increment while running (≈0.1 s at 25.175 MHz).
- DEB_CYCLES, 250000: cycles the synchronised button must be stable before its level is accepted.
- DEATH_CYCLES, 12587500: freeze length after a collision before GAME_OVER (≈0.5 s).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high; clears all state
- btn  in  1  raw jump/start button, asynchronous, active-high
- collision  in  1  synchronous, level, from the collision detector
- score_halt  out  1  1 = freeze score/scroll datapath
- score_reset  out  1  one-cycle pulse that clears the score datapath
- score_tick  out  1  one-cycle pulse per score increment
- cur_score  out  16  BCD, digit 0 in [3:0], up to digit 3 in [15:12]
- hi_score  out  16  BCD, same layout
- game_over  out  1  high in GAME_OVER
- state  out  2  current state (for the sprite/text renderers)

Behaviour:
- Reset (asynchronous assert, synchronous release by design):
  - state=ATTRACT, score_halt=1, score_reset=0, score_tick=0.
  - cur_score=0, hi_score=0, game_over=0.
  - Divider, debounce and death counters = 0.
- Button path:
  - 2-flop synchroniser, then a debouncer: the accepted level changes only after DEB_CYCLES consecutive equal samples.
  - start_evt = one-cycle pulse on the accepted rising edge.
  - Holding the button produces no further events.
- States (encoding 0..3): ATTRACT, RUNNING, DYING, GAME_OVER.
- ATTRACT:
  - score_halt=1.
  - start_evt → RUNNING; score_reset pulses in that transition cycle; cur_score←0; divider←0.
- RUNNING:
  - score_halt=0.
  - Divider counts 0..TICK_DIV-1. At terminal count: score_tick=1 for one cycle, cur_score increments as BCD with ripple carry, divider←0.
  - At 9999 the score saturates: tick still pulses, value holds.
  - collision=1 → DYING in the next cycle; death counter←0.
  - Collision has priority over a same-cycle terminal count: no tick, no increment, divider holds.
  - start_evt is ignored.
- DYING:
  - score_halt=1.
  - Counts DEATH_CYCLES cycles, then → GAME_OVER.
  - In that transition cycle, hi_score←cur_score if cur_score > hi_score (unsigned compare of the 16-bit BCD word, valid since digits are ordered).
  - Button and collision are ignored.
- GAME_OVER:
  - game_over=1, score_halt=1, cur_score holds for display.
  - start_evt → RUNNING with the same score_reset/clear actions as from ATTRACT. hi_score is kept.
  - A press that began during DYING does not restart; a new rising edge is required.
- Other rules:
  - collision outside RUNNING is ignored.
  - score_tick is 0 whenever state≠RUNNING.
  - Reset mid-operation returns to ATTRACT and clears hi_score.

Decomposition:
- Shared package `game_pkg`:
  - state localparams ST_ATTRACT=0, ST_RUNNING=1, ST_DYING=2, ST_GAME_OVER=3.
  - BCD_DIGITS=4, SCORE_W=16.
  - Default TICK_DIV, which the renderers also use.
- One natural sub-module: `btn_debounce` (synchroniser + debounce counter + rising-edge pulse), parameterised by DEB_CYCLES.
- BCD increment and compare stay inline.

Test Plan (TICK_DIV=10, DEB_CYCLES=4, DEATH_CYCLES=8):
- Reset then idle 50 cycles → state=0, score_halt=1, cur_score=0x0000, no ticks.
- Press btn for 6 cycles → exactly one score_reset pulse; state=1; first score_tick 10 cycles later; after 35 ticks cur_score=0x0035.
- Button glitch of 2 cycles in ATTRACT → no start; state stays 0.
- Preload 9999 by running (or force), then one more tick → cur_score stays 0x9999 and score_tick still pulses.
- collision asserted on the terminal-count cycle at score 0x0012 → no tick, cur_score=0x0012; state=2; 8 cycles later state=3, game_over=1, hi_score=0x0012.
- Second game reaching 0x0007, then collision → hi_score stays 0x0012.
- Third game, assert reset mid-RUNNING → immediately state=0, hi_score=0x0000.
